// File: rtl/amo_sequencer_pkg.sv
// Shared types for the RV64A atomic sequencer: op and state encodings, bus widths,
// and the op-support check. AMO_MINMAX_EN enables MIN/MAX/MINU/MAXU.
package amo_sequencer_pkg;
    localparam int XLEN   = 64;
    localparam int STRB_W = XLEN / 8;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        OP_LR   = 4'd0,
        OP_SC   = 4'd1,
        OP_SWAP = 4'd2,
        OP_ADD  = 4'd3,
        OP_XOR  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_MIN  = 4'd7,
        OP_MAX  = 4'd8,
        OP_MINU = 4'd9,
        OP_MAXU = 4'd10
    } amo_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } amo_state_t;

    // Encodings above OP_MAXU, and min/max when the feature is off, complete as illegal.
    function automatic logic op_supported(input logic [3:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LR, OP_SC, OP_SWAP, OP_ADD, OP_XOR, OP_AND, OP_OR: ok = 1'b1;
`ifdef AMO_MINMAX_EN
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction
endpackage

// File: rtl/amo_sequencer_if.sv
// Data-bus request/response bundle between the atomic sequencer and memory.
interface amo_sequencer_if;
    import amo_sequencer_pkg::*;

    logic              dreq_valid;
    logic              dreq_write;
    word_t             dreq_addr;
    logic [STRB_W-1:0] dreq_strobe;
    word_t             dreq_data;
    logic              dresp_ok;
    word_t             dresp_data;

    modport master (
        output dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
        input  dresp_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
        output dresp_ok, dresp_data
    );
endinterface

// File: rtl/amo_sequencer_alu.sv
// Combinational AMO update: new = f(op, old, src) at 32- or 64-bit width.
// Word results are sign-extended; only the low half reaches the bus.
// MIN/MAX/MINU/MAXU exist only with AMO_MINMAX_EN.
module amo_sequencer_alu
    import amo_sequencer_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic       is_word_i,
    input  word_t      old_i,
    input  word_t      src_i,
    output word_t      new_o
);
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] r32;
    word_t       r64;
`ifdef AMO_MINMAX_EN
    logic lt_s32, lt_u32, lt_s64, lt_u64;
`endif

    // Compute both widths in parallel and select by is_word at the end.
    always_comb begin
        a32 = old_i[31:0];
        b32 = src_i[31:0];
        r32 = b32;
        r64 = src_i;
`ifdef AMO_MINMAX_EN
        lt_s32 = $signed(a32) < $signed(b32);
        lt_u32 = a32 < b32;
        lt_s64 = $signed(old_i) < $signed(src_i);
        lt_u64 = old_i < src_i;
`endif
        case (op_i)
            OP_ADD: begin r32 = a32 + b32;  r64 = old_i + src_i;  end
            OP_XOR: begin r32 = a32 ^ b32;  r64 = old_i ^ src_i;  end
            OP_AND: begin r32 = a32 & b32;  r64 = old_i & src_i;  end
            OP_OR:  begin r32 = a32 | b32;  r64 = old_i | src_i;  end
`ifdef AMO_MINMAX_EN
            OP_MIN:  begin r32 = lt_s32 ? a32 : b32; r64 = lt_s64 ? old_i : src_i; end
            OP_MAX:  begin r32 = lt_s32 ? b32 : a32; r64 = lt_s64 ? src_i : old_i; end
            OP_MINU: begin r32 = lt_u32 ? a32 : b32; r64 = lt_u64 ? old_i : src_i; end
            OP_MAXU: begin r32 = lt_u32 ? b32 : a32; r64 = lt_u64 ? src_i : old_i; end
`endif
            default: ;
        endcase
        new_o = is_word_i ? {{32{r32[31]}}, r32} : r64;
    end
endmodule

// File: rtl/amo_sequencer.sv
// Memory-stage sequencer for RV64A LR/SC/AMO. Issues bus read and/or write and
// drives the reservation tracker. AMO_MINMAX_EN enables MIN/MAX/MINU/MAXU.
//
//  state    | meaning
//  ST_IDLE  | waiting for start; SC queries the reservation here
//  ST_READ  | bus load in flight (LR and AMO)
//  ST_WRITE | bus store in flight (AMO and successful SC)
//  ST_DONE  | one-cycle done pulse with rd_data / illegal
module amo_sequencer
    import amo_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [3:0] op_i,
    input  logic       is_word_i,
    input  word_t      addr_i,
    input  word_t      src_i,
    output logic       busy_o,
    output logic       done_o,
    output word_t      rd_data_o,
    output logic       illegal_o,
    amo_sequencer_if.master bus,
    output logic       resv_set_o,
    output logic       resv_query_o,
    output word_t      resv_addr_o,
    input  logic       resv_hit_i
);
    amo_state_t  state_q, state_d;
    logic [3:0]  op_q;
    logic        word_q;
    word_t       addr_q, src_q, old_q, new_q, rd_q;
    logic        illegal_q;
    word_t       rdata_ext;
    word_t       alu_new;

    // Pick the addressed 32-bit lane for .W and sign-extend it.
    always_comb begin
        if (word_q)
            rdata_ext = addr_q[2] ? {{32{bus.dresp_data[63]}}, bus.dresp_data[63:32]}
                                  : {{32{bus.dresp_data[31]}}, bus.dresp_data[31:0]};
        else
            rdata_ext = bus.dresp_data;
    end

    amo_sequencer_alu u_alu (
        .op_i      (op_q),
        .is_word_i (word_q),
        .old_i     (rdata_ext),
        .src_i     (src_q),
        .new_o     (alu_new)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                if (!op_supported(op_i))  state_d = ST_DONE;
                else if (op_i == OP_SC)   state_d = resv_hit_i ? ST_WRITE : ST_DONE;
                else                      state_d = ST_READ;
            end
            ST_READ:  if (bus.dresp_ok) state_d = (op_q == OP_LR) ? ST_DONE : ST_WRITE;
            ST_WRITE: if (bus.dresp_ok) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operand latch, old value capture and rd result.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            word_q    <= 1'b0;
            addr_q    <= '0;
            src_q     <= '0;
            old_q     <= '0;
            new_q     <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) begin
                    op_q      <= op_i;
                    word_q    <= is_word_i;
                    addr_q    <= addr_i;
                    src_q     <= src_i;
                    old_q     <= '0;
                    new_q     <= src_i;
                    illegal_q <= !op_supported(op_i);
                    // A failed SC reports 1 without touching the bus.
                    rd_q      <= (op_i == OP_SC && !resv_hit_i) ? word_t'(1) : '0;
                end
                ST_READ: if (bus.dresp_ok) begin
                    old_q <= rdata_ext;
                    new_q <= alu_new;
                    rd_q  <= rdata_ext;
                end
                ST_WRITE: if (bus.dresp_ok) rd_q <= old_q;
                default: ;
            endcase
        end
    end

    // Outputs; everything idles at zero outside its owning state.
    always_comb begin
        busy_o          = 1'b0;
        done_o          = 1'b0;
        rd_data_o       = '0;
        illegal_o       = 1'b0;
        bus.dreq_valid  = 1'b0;
        bus.dreq_write  = 1'b0;
        bus.dreq_addr   = '0;
        bus.dreq_strobe = '0;
        bus.dreq_data   = '0;
        resv_set_o      = 1'b0;
        resv_query_o    = 1'b0;
        resv_addr_o     = '0;
        case (state_q)
            ST_IDLE: begin
                busy_o = start_i && !reset;
                if (start_i && !reset && op_i == OP_SC) begin
                    resv_query_o = 1'b1;
                    resv_addr_o  = addr_i;
                end
            end
            ST_READ: begin
                busy_o         = 1'b1;
                bus.dreq_valid = 1'b1;
                bus.dreq_addr  = {addr_q[XLEN-1:3], 3'b000};
                if (bus.dresp_ok && op_q == OP_LR && !reset) begin
                    resv_set_o  = 1'b1;
                    resv_addr_o = addr_q;
                end
            end
            ST_WRITE: begin
                busy_o          = 1'b1;
                bus.dreq_valid  = 1'b1;
                bus.dreq_write  = 1'b1;
                bus.dreq_addr   = {addr_q[XLEN-1:3], 3'b000};
                bus.dreq_strobe = word_q ? (addr_q[2] ? 8'hF0 : 8'h0F) : 8'hFF;
                bus.dreq_data   = word_q ? {2{new_q[31:0]}} : new_q;
            end
            ST_DONE: begin
                done_o    = 1'b1;
                rd_data_o = rd_q;
                illegal_o = illegal_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer with a one-wait-state bus responder and a
// scoreboard of expected completions.
module tb_amo_sequencer;
    import amo_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] op;
    logic       is_word;
    word_t      addr, src;
    logic       busy, done, illegal;
    word_t      rd_data;
    logic       resv_set, resv_query, resv_hit;
    word_t      resv_addr;
    logic       hit_sel;

    word_t      mem_data;
    word_t      last_addr, wr_data;
    logic [7:0] wr_strobe;
    int         nreq = 0, nset = 0, nvalid = 0;
    int         checks = 0, errors = 0;

    typedef struct {
        word_t      rd;
        logic       ill;
        int         nreq;
        int         nset;
        word_t      wdata;
        logic [7:0] strb;
        word_t      baddr;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    amo_sequencer_if bus ();

    assign resv_hit = resv_query & hit_sel;

    amo_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .op_i         (op),
        .is_word_i    (is_word),
        .addr_i       (addr),
        .src_i        (src),
        .busy_o       (busy),
        .done_o       (done),
        .rd_data_o    (rd_data),
        .illegal_o    (illegal),
        .bus          (bus),
        .resv_set_o   (resv_set),
        .resv_query_o (resv_query),
        .resv_addr_o  (resv_addr),
        .resv_hit_i   (resv_hit)
    );

    always @(posedge clk) begin
        if (bus.dreq_valid) nvalid++;
        if (resv_set) nset++;
    end

    // Bus model: answers each request on its second cycle of dreq_valid.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.dresp_ok   = 1'b0;
        bus.dresp_data = '0;
        forever begin
            @(negedge clk);
            bus.dresp_ok = 1'b0;
            if (!bus.dreq_valid) wcnt = 0;
            else if (wcnt == 1) begin
                wcnt = 0;
                bus.dresp_ok = 1'b1;
                nreq++;
                last_addr = bus.dreq_addr;
                if (bus.dreq_write) begin
                    wr_data   = bus.dreq_data;
                    wr_strobe = bus.dreq_strobe;
                end else begin
                    bus.dresp_data = mem_data;
                end
            end else wcnt = 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one atomic from a negedge; returns at the negedge after done.
    task automatic do_op(input logic [3:0] o, input logic w, input word_t a, input word_t s,
                         input word_t m, input logic h, input word_t e_rd, input logic e_ill,
                         input int e_nreq, input int e_nset, input word_t e_wd,
                         input logic [7:0] e_strb, input logic poke);
        exp_t e, got;
        int   lat, exp_lat, nreq0, nset0, nval0;
        e.rd = e_rd; e.ill = e_ill; e.nreq = e_nreq; e.nset = e_nset;
        e.wdata = e_wd; e.strb = e_strb; e.baddr = a & ~64'h7;
        exp_lat = 1 + 2 * e_nreq;
        nreq0 = nreq; nset0 = nset; nval0 = nvalid;
        wr_strobe = 8'h00; wr_data = '0; last_addr = '0;
        mem_data = m; hit_sel = h;
        op = o; is_word = w; addr = a; src = s; start = 1'b1;
        sb.push_back(e);
        #1;
        chk("busy_at_start", {63'd0, busy}, 64'd1);
        chk("resv_query", {63'd0, resv_query}, {63'd0, o == 4'(OP_SC)});
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 2) begin
                start = 1'b1; op = OP_SC; addr = 64'h1000;
                #1;
                chk("no_query_when_busy", {63'd0, resv_query}, 64'd0);
            end
            if (poke && lat == 3) start = 1'b0;
        end
        got = sb.pop_front();
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL done_timeout: op %0d observed no done expected done within 30 cycles", o);
        end else begin
            chk("rd_data", rd_data, got.rd);
            chk("illegal", {63'd0, illegal}, {63'd0, got.ill});
            chk("busy_at_done", {63'd0, busy}, 64'd0);
            chk("latency", 64'(lat), 64'(exp_lat));
            chk("bus_txns", 64'(nreq - nreq0), 64'(got.nreq));
            chk("resv_set_cnt", 64'(nset - nset0), 64'(got.nset));
            if (got.nreq == 0) chk("no_dreq_valid", 64'(nvalid - nval0), 64'd0);
            else chk("bus_addr", last_addr, got.baddr);
            chk("wr_strobe", {56'd0, wr_strobe}, {56'd0, got.strb});
            if (got.strb != 8'h00) chk("wr_data", wr_data, got.wdata);
        end
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = '0; is_word = 1'b0; addr = '0; src = '0;
        hit_sel = 1'b0; mem_data = '0; last_addr = '0; wr_data = '0; wr_strobe = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        chk("rst_resv_set", {63'd0, resv_set}, 64'd0);

        // LR.D
        do_op(OP_LR, 1'b0, 64'h8000_1000, 64'd0, 64'h1234, 1'b0,
              64'h1234, 1'b0, 1, 1, 64'd0, 8'h00, 1'b0);
        // SC.W success, upper lane
        do_op(OP_SC, 1'b1, 64'h8000_1004, 64'hDEAD_BEEF, 64'd0, 1'b1,
              64'd0, 1'b0, 1, 0, 64'hDEAD_BEEF_DEAD_BEEF, 8'hF0, 1'b0);
        // SC.D failure
        do_op(OP_SC, 1'b0, 64'h8000_1008, 64'h55, 64'd0, 1'b0,
              64'd1, 1'b0, 0, 0, 64'd0, 8'h00, 1'b0);
        // AMOADD.W overflow, lower lane
        do_op(OP_ADD, 1'b1, 64'h8000_2000, 64'd1, 64'hAAAA_AAAA_7FFF_FFFF, 1'b0,
              64'h0000_0000_7FFF_FFFF, 1'b0, 2, 0, 64'h8000_0000_8000_0000, 8'h0F, 1'b0);
        // AMOADD.W wrap, upper lane, negative old
        do_op(OP_ADD, 1'b1, 64'h8000_2004, 64'd3, 64'hFFFF_FFFE_0000_0000, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 2, 0, 64'h0000_0001_0000_0001, 8'hF0, 1'b0);
        // AMOSWAP.D with a start pulse while busy
        do_op(OP_SWAP, 1'b0, 64'h8000_300B, 64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444, 1'b0,
              64'h1111_2222_3333_4444, 1'b0, 2, 0, 64'h5555_6666_7777_8888, 8'hFF, 1'b1);
        // AMOXOR.D
        do_op(OP_XOR, 1'b0, 64'h8000_3010, 64'h0F0F_0F0F_FFFF_FFFF, 64'hF0F0_F0F0_0000_FFFF, 1'b0,
              64'hF0F0_F0F0_0000_FFFF, 1'b0, 2, 0, 64'hFFFF_FFFF_FFFF_0000, 8'hFF, 1'b0);
        // AMOAND.W lower lane
        do_op(OP_AND, 1'b1, 64'h8000_3018, 64'h0000_0000_FFFF_0FF0, 64'h1234_5678_8765_F00F, 1'b0,
              64'hFFFF_FFFF_8765_F00F, 1'b0, 2, 0, 64'h8765_0000_8765_0000, 8'h0F, 1'b0);
        // AMOOR.D
        do_op(OP_OR, 1'b0, 64'h8000_3020, 64'h1, 64'h100, 1'b0,
              64'h100, 1'b0, 2, 0, 64'h101, 8'hFF, 1'b0);
`ifdef AMO_MINMAX_EN
        do_op(OP_MIN, 1'b0, 64'h8000_4000, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        do_op(OP_MAXU, 1'b1, 64'h8000_4004, 64'h0000_0000_FFFF_FFF0, 64'h0000_0001_0000_0000, 1'b0,
              64'h1, 1'b0, 2, 0, 64'hFFFF_FFF0_FFFF_FFF0, 8'hF0, 1'b0);
        do_op(OP_MAX, 1'b1, 64'h8000_4008, 64'd3, 64'h0000_0000_FFFF_FFF0, 1'b0,
              64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 2, 0, 64'h0000_0003_0000_0003, 8'h0F, 1'b0);
`else
        do_op(OP_MIN, 1'b0, 64'h8000_4000, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              64'd0, 1'b1, 0, 0, 64'd0, 8'h00, 1'b0);
        do_op(OP_MAXU, 1'b1, 64'h8000_4004, 64'h0000_0000_FFFF_FFF0, 64'h0000_0001_0000_0000, 1'b0,
              64'd0, 1'b1, 0, 0, 64'd0, 8'h00, 1'b0);
`endif
        // Undefined encoding
        do_op(4'd12, 1'b0, 64'h8000_5000, 64'd7, 64'd0, 1'b0,
              64'd0, 1'b1, 0, 0, 64'd0, 8'h00, 1'b0);

        // Reset while the AMO store is outstanding
        n = nset;
        mem_data = 64'h10; op = OP_ADD; is_word = 1'b0; addr = 64'h8000_6000; src = 64'h1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !(bus.dreq_valid && bus.dreq_write); i++) @(negedge clk);
        checks++;
        if (!(bus.dreq_valid && bus.dreq_write)) begin
            errors++;
            $display("FAIL write_phase_timeout: observed no store expected store within 20 cycles");
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        chk("midrst_no_done_later", {63'd0, done}, 64'd0);
        chk("midrst_no_resv_set", 64'(nset - n), 64'd0);

        // Recovery: LR.W upper lane, negative value
        do_op(OP_LR, 1'b1, 64'h8000_7004, 64'd0, 64'h8000_0000_0000_0000, 1'b0,
              64'hFFFF_FFFF_8000_0000, 1'b0, 1, 1, 64'd0, 8'h00, 1'b0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
